// File: rtl/bus_drv_endpoint.sv
// rtl/bus_drv_endpoint.sv - drive-port endpoint: TX/RX FIFOs on the pndng/pop and push/D_push handshake
// Optional address filter on pushes: BUS_EP_ADDR_FILTER_EN.
module bus_drv_endpoint #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8,
    parameter int ID      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_wr,
    input  logic [PCKG_SZ-1:0]         tx_data,
    output logic                       tx_full,
    output logic                       tx_ovf,
    output logic                       pndng,
    output logic [PCKG_SZ-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         D_push,
    input  logic                       rx_rd,
    output logic [PCKG_SZ-1:0]         rx_data,
    output logic                       rx_valid,
    output logic [$clog2(DEPTH+1)-1:0] tx_count,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic [7:0]                 rx_drop,
    output logic                       pop_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    MY_ID    = 8'(ID);
`ifdef BUS_EP_ADDR_FILTER_EN
    localparam bit ADDR_FILTER = 1'b1;
`else
    localparam bit ADDR_FILTER = 1'b0;
`endif

    logic [PCKG_SZ-1:0] tx_mem [DEPTH];
    logic [PCKG_SZ-1:0] rx_mem [DEPTH];
    logic [PW-1:0]      tx_wp, tx_rp, tx_rp_nxt;
    logic [PW-1:0]      rx_wp, rx_rp, rx_rp_nxt;
    logic [CW-1:0]      tx_cnt_nxt, rx_cnt_nxt;
    logic               tx_pop_ok, tx_wr_ok;
    logic               rx_rd_ok, rx_acc, rx_wr_ok, addr_hit;

    assign pndng    = (tx_count != '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign rx_valid = (rx_count != '0);

    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign tx_pop_ok = pop && pndng;
    assign tx_wr_ok  = tx_wr && (!tx_full || tx_pop_ok);
    assign tx_rp_nxt = tx_pop_ok ? tx_rp + 1'b1 : tx_rp;

    assign addr_hit  = (D_push[PCKG_SZ-1 -: 8] == MY_ID) || (D_push[PCKG_SZ-1 -: 8] == 8'hFF);
    assign rx_acc    = push && (!ADDR_FILTER || addr_hit);
    assign rx_rd_ok  = rx_rd && rx_valid;
    assign rx_wr_ok  = rx_acc && (rx_count != FULL_CNT || rx_rd_ok);
    assign rx_rp_nxt = rx_rd_ok ? rx_rp + 1'b1 : rx_rp;

    always_comb begin
        tx_cnt_nxt = tx_count;
        if (tx_wr_ok && !tx_pop_ok)
            tx_cnt_nxt = tx_count + 1'b1;
        else if (!tx_wr_ok && tx_pop_ok)
            tx_cnt_nxt = tx_count - 1'b1;
        rx_cnt_nxt = rx_count;
        if (rx_wr_ok && !rx_rd_ok)
            rx_cnt_nxt = rx_count + 1'b1;
        else if (!rx_wr_ok && rx_rd_ok)
            rx_cnt_nxt = rx_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tx_wr_ok && !reset)
            tx_mem[tx_wp] <= tx_data;
        if (rx_wr_ok && !reset)
            rx_mem[rx_wp] <= D_push;
    end

    // Head registers look ahead one edge; a write landing in the next head slot is bypassed.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            D_pop    <= '0;
            tx_ovf   <= 1'b0;
            pop_err  <= 1'b0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
            rx_data  <= '0;
            rx_drop  <= '0;
        end else begin
            if (tx_wr_ok)
                tx_wp <= tx_wp + 1'b1;
            tx_rp    <= tx_rp_nxt;
            tx_count <= tx_cnt_nxt;
            if (tx_cnt_nxt != '0)
                D_pop <= (tx_wr_ok && tx_rp_nxt == tx_wp) ? tx_data : tx_mem[tx_rp_nxt];
            if (tx_wr && !tx_wr_ok)
                tx_ovf <= 1'b1;
            if (pop && !pndng)
                pop_err <= 1'b1;

            if (rx_wr_ok)
                rx_wp <= rx_wp + 1'b1;
            rx_rp    <= rx_rp_nxt;
            rx_count <= rx_cnt_nxt;
            if (rx_cnt_nxt != '0)
                rx_data <= (rx_wr_ok && rx_rp_nxt == rx_wp) ? D_push : rx_mem[rx_rp_nxt];
            if (rx_acc && !rx_wr_ok && rx_drop != 8'hFF)
                rx_drop <= rx_drop + 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_drv_endpoint.sv
// tb/tb_bus_drv_endpoint.sv - directed and random checks of bus_drv_endpoint against a queue model
module tb_bus_drv_endpoint;
    localparam int PCKG_SZ = 16;
    localparam int DEPTH   = 8;
    localparam int ID      = 3;
    localparam int CW      = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               tx_wr = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
    logic [PCKG_SZ-1:0] tx_data = '0, D_push = '0;
    logic               tx_full, tx_ovf, pndng, rx_valid, pop_err;
    logic [PCKG_SZ-1:0] D_pop, rx_data;
    logic [CW-1:0]      tx_count, rx_count;
    logic [7:0]         rx_drop;

    int checks = 0;
    int errors = 0;

    logic [PCKG_SZ-1:0] tq[$];
    logic [PCKG_SZ-1:0] rq[$];
    logic [PCKG_SZ-1:0] m_dpop, m_rxdata, got_w;
    logic               m_ovf, m_perr;
    int                 m_drop;

    bus_drv_endpoint #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH), .ID(ID)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .tx_ovf(tx_ovf), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_count(tx_count), .rx_count(rx_count), .rx_drop(rx_drop), .pop_err(pop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [PCKG_SZ-1:0] w);
`ifdef BUS_EP_ADDR_FILTER_EN
        return (w[15:8] == 8'(ID)) || (w[15:8] == 8'hFF);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit pop_ok, rd_ok;
        if (reset) begin
            tq.delete(); rq.delete();
            m_dpop = '0; m_rxdata = '0; m_ovf = 0; m_perr = 0; m_drop = 0;
            return;
        end
        pop_ok = pop && tq.size() > 0;
        if (pop && tq.size() == 0) m_perr = 1;
        if (tx_wr && !(tq.size() < DEPTH || pop_ok)) m_ovf = 1;
        if (pop_ok) void'(tq.pop_front());
        if (tx_wr && (tq.size() < DEPTH)) tq.push_back(tx_data);
        if (tq.size() > 0) m_dpop = tq[0];

        rd_ok = rx_rd && rq.size() > 0;
        if (rd_ok) void'(rq.pop_front());
        if (push && addr_ok(D_push)) begin
            if (rq.size() < DEPTH) rq.push_back(D_push);
            else if (m_drop < 255) m_drop++;
        end
        if (rq.size() > 0) m_rxdata = rq[0];
    endtask

    task automatic compare_all();
        check("pndng", 32'(pndng), 32'(tq.size() != 0));
        check("tx_full", 32'(tx_full), 32'(tq.size() == DEPTH));
        check("tx_count", 32'(tx_count), 32'(tq.size()));
        check("D_pop", 32'(D_pop), 32'(m_dpop));
        check("tx_ovf", 32'(tx_ovf), 32'(m_ovf));
        check("pop_err", 32'(pop_err), 32'(m_perr));
        check("rx_valid", 32'(rx_valid), 32'(rq.size() != 0));
        check("rx_count", 32'(rx_count), 32'(rq.size()));
        check("rx_data", 32'(rx_data), 32'(m_rxdata));
        check("rx_drop", 32'(rx_drop), 32'(m_drop));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        tx_wr = 0; pop = 0; push = 0; rx_rd = 0; reset = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        do_reset();
        repeat (5) tick();
        check("rst_pndng", 32'(pndng), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_counts", 32'({tx_count, rx_count, rx_drop}), 0);
        check("rst_dpop", 32'(D_pop), 0);

        tx_wr = 1; tx_data = 16'h0301; tick();
        check("wr1_pndng", 32'(pndng), 1);
        check("wr1_dpop", 32'(D_pop), 32'h0301);
        tx_data = 16'h0302; tick();
        tx_wr = 0; pop = 1; tick();
        check("pop1_dpop", 32'(D_pop), 32'h0302);
        tick();
        check("pop2_pndng", 32'(pndng), 0);
        idle(); tick();

        for (int i = 0; i < 9; i++) begin
            tx_wr = 1; tx_data = 16'h0400 + 16'(i); tick();
        end
        idle(); tick();
        check("fill_full", 32'(tx_full), 1);
        check("fill_count", 32'(tx_count), 8);
        check("fill_ovf", 32'(tx_ovf), 1);
        for (int i = 0; i < 8; i++) begin
            got_w = D_pop;
            check("drain_word", 32'(got_w), 32'h0400 + i);
            pop = 1; tick();
        end
        idle(); tick();
        check("drain_empty", 32'(pndng), 0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            push = 1; D_push = 16'h0500 + 16'(i); tick();
        end
        idle(); tick();
        check("rx_fill_count", 32'(rx_count), 8);
        check("rx_fill_drop", 32'(rx_drop), 2);
        push = 1; rx_rd = 1; D_push = 16'h05AA; tick();
        idle(); tick();
        check("rx_rdpush_count", 32'(rx_count), 8);
        check("rx_rdpush_drop", 32'(rx_drop), 2);
        for (int i = 1; i < 8; i++) begin
            check("rx_drain", 32'(rx_data), 32'h0500 + i);
            rx_rd = 1; tick();
        end
        check("rx_last", 32'(rx_data), 32'h05AA);
        rx_rd = 1; tick();
        rx_rd = 1; tick();
        idle(); tick();
        check("rx_empty", 32'(rx_valid), 0);

        do_reset();
        pop = 1; tick();
        idle(); tick();
        check("perr_set", 32'(pop_err), 1);
        check("perr_count", 32'(tx_count), 0);
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1; tx_data = 16'h0600 + 16'(i); tick();
        end
        check("burst_count", 32'(tx_count), 5);
        reset = 1; tx_wr = 1; push = 1; tick();
        idle(); tick();
        check("rst_mid_count", 32'(tx_count), 0);
        check("rst_mid_perr", 32'(pop_err), 0);
        check("rst_mid_dpop", 32'(D_pop), 0);
        check("rst_mid_rx", 32'(rx_count), 0);

        push = 1; D_push = 16'h0311; tick();
        D_push = 16'h0522; tick();
        D_push = 16'hFF33; tick();
        idle(); tick();
`ifdef BUS_EP_ADDR_FILTER_EN
        check("filt_count", 32'(rx_count), 2);
        check("filt_head", 32'(rx_data), 32'h0311);
        rx_rd = 1; tick(); idle(); tick();
        check("filt_second", 32'(rx_data), 32'hFF33);
`else
        check("nofilt_count", 32'(rx_count), 3);
        check("nofilt_head", 32'(rx_data), 32'h0311);
        rx_rd = 1; tick(); idle(); tick();
        check("nofilt_second", 32'(rx_data), 32'h0522);
`endif
        check("filt_drop", 32'(rx_drop), 0);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tx_wr   = ($urandom_range(0, 99) < 55);
            pop     = ($urandom_range(0, 99) < 45);
            push    = ($urandom_range(0, 99) < 55);
            rx_rd   = ($urandom_range(0, 99) < 40);
            tx_data = 16'($urandom);
            D_push  = 16'($urandom);
            case ($urandom_range(0, 3))
                0: D_push[15:8] = 8'(ID);
                1: D_push[15:8] = 8'hFF;
                default: ;
            endcase
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
